mem_read_unit: RTL and testbench
================================

Name: mem_read_unit

Overview:
- Read-side bus sequencer for the 6502 core. The control unit issues a read request. The block drives the address bus, honours RDY wait states, and captures one byte or a little-endian 16-bit word from the data bus.
- It returns the result with a one-cycle done pulse.
- It is the counterpart of the 8-bit register latches: it produces the values those registers load (operands, vectors, indirect pointers).

Parameters:
- ADDR_W, 16, address bus width; the wrap logic assumes 16.
- RESET_AB, 16'h0000, value driven on ab during and after reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- req  input  1  read request, sampled only in IDLE
- wide  input  1  1 = 16-bit read (lo at addr, hi at addr+1); 0 = 8-bit read
- zp_wrap  input  1  1 = hi-byte address wraps within the page of addr
- addr_in  input  ADDR_W  start address, latched with req
- rdy  input  1  6502 RDY; 0 stalls the current bus read
- db_in  input  8  data bus from memory
- ab  output  ADDR_W  address bus
- ab_valid  output  1  high while a bus read is in progress (== busy)
- busy  output  1  high from request acceptance until completion
- done  output  1  one-cycle completion pulse
- data_out  output  16  read result; valid when done=1, held until the next completion

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state=IDLE, ab=RESET_AB
  - busy=0, ab_valid=0, done=0
  - data_out=16'h0000, internal lo latch=8'h00
- Reset mid-operation aborts the read: no done pulse and no data_out update.
- States: IDLE, LO, HI.
- IDLE:
  - On a clk edge with req=1: latch wide, zp_wrap, addr_in; set ab<=addr_in, busy<=1, state<=LO.
  - With req=0: ab holds its last value.
- LO:
  - rdy=0: hold everything (ab, state, latches).
  - rdy=1 and wide=0: data_out<={8'h00, db_in}, done<=1, busy<=0, state<=IDLE.
  - rdy=1 and wide=1: lo<=db_in, ab<=next_addr, state<=HI.
- HI:
  - rdy=0: hold.
  - rdy=1: data_out<={db_in, lo}, done<=1, busy<=0, state<=IDLE.
- next_addr rules:
  - zp_wrap=1: {addr[15:8], addr[7:0]+1}, so 16'h12FF gives 16'h1200.
  - zp_wrap=0: addr+1 modulo 2^16, so 16'hFFFF gives 16'h0000.
- done:
  - Registered; high for exactly the one cycle after the completing edge, then cleared.
  - A req present during the done cycle is accepted on that edge (state is IDLE), so back-to-back reads run with no idle gap.
- data_out updates atomically at completion only; it is never partially updated mid-read.
- req is ignored while busy=1. Requests are not queued.
- Latency with rdy held at 1, counting edges after the accepting edge:
  - 8-bit read: done after 1 edge.
  - 16-bit read: done after 2 edges.
  - Each rdy=0 cycle adds one.
- ab_valid = busy (combinational).

Test Plan:
- Reset: rst=0 with clk running → ab=0000, busy=0, done=0, data_out=0000. Release rst → outputs unchanged until req.
- 8-bit read: addr_in=16'h0200, wide=0, mem[0200]=8'hA9, rdy=1.
  - Required: ab=0200 for one cycle, then done=1 for one cycle with data_out=00A9.
- 16-bit read with wrap: addr_in=16'hFFFF, wide=1, zp_wrap=0, mem[FFFF]=34, mem[0000]=12.
  - Required: ab sequence FFFF then 0000; data_out=1234.
- Zero-page wrap: addr_in=16'h00FF, wide=1, zp_wrap=1, mem[00FF]=CD, mem[0000]=AB.
  - Required: ab sequence 00FF then 0000 (not 0100); data_out=ABCD.
- Wait states: 16-bit read at 16'h3000 with rdy=0 for 3 cycles in LO and 2 cycles in HI.
  - Required: ab held at each address during its stall; done on the 7th edge after acceptance.
  - Required: no done and no data_out change during the stall.
- Back-to-back and abort cases:
  - req held high across two 8-bit reads → two done pulses on consecutive-read timing, second data correct.
  - rst asserted in HI → no done pulse; data_out=0000.

Source files
------------

// File: rtl/mem_read_unit.sv
// Purpose: read-side bus sequencer; fetches one byte or a little-endian word and returns it with a done pulse.
// Latency: done one edge after the last data edge (1 edge for a byte, 2 for a word, +1 per rdy=0 cycle).
// Backpressure: rdy=0 freezes the current bus read; req is ignored while busy, nothing is queued.
module mem_read_unit #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_AB = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wide,
    input  logic              zp_wrap,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              rdy,
    input  logic [7:0]        db_in,
    output logic [ADDR_W-1:0] ab,
    output logic              ab_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ab;
    logic [ADDR_W-1:0] w_ab_nxt;
    logic [ADDR_W-1:0] w_next_addr;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_wide;
    logic              w_wide_nxt;
    logic              r_zp_wrap;
    logic              w_zp_wrap_nxt;
    logic [7:0]        r_lo;
    logic [7:0]        w_lo_nxt;
    logic [15:0]       r_data;
    logic [15:0]       w_data_nxt;

    // Hi-byte address: either stays inside the page of the lo byte or carries across the full bus.
    always_comb begin
        w_next_addr = r_ab + ADDR_W'(1);
        if (r_zp_wrap) begin
            w_next_addr = {r_ab[ADDR_W-1:8], r_ab[7:0] + 8'd1};
        end
    end

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        w_state_nxt   = r_state;
        w_ab_nxt      = r_ab;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_wide_nxt    = r_wide;
        w_zp_wrap_nxt = r_zp_wrap;
        w_lo_nxt      = r_lo;
        w_data_nxt    = r_data;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_wide_nxt    = wide;
                    w_zp_wrap_nxt = zp_wrap;
                    w_ab_nxt      = addr_in;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_LO;
                end
            end
            S_LO: begin
                if (rdy) begin
                    if (r_wide) begin
                        w_lo_nxt    = db_in;
                        w_ab_nxt    = w_next_addr;
                        w_state_nxt = S_HI;
                    end else begin
                        w_data_nxt  = {8'h00, db_in};
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_HI: begin
                if (rdy) begin
                    w_data_nxt  = {db_in, r_lo};
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any read in flight without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ab      <= RESET_AB;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wide    <= 1'b0;
            r_zp_wrap <= 1'b0;
            r_lo      <= 8'h00;
            r_data    <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_ab      <= w_ab_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_wide    <= w_wide_nxt;
            r_zp_wrap <= w_zp_wrap_nxt;
            r_lo      <= w_lo_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign ab       = r_ab;
    assign busy     = r_busy;
    assign ab_valid = r_busy;
    assign done     = r_done;
    assign data_out = r_data;

endmodule

// File: tb/tb_mem_read_unit.sv
// Bench for mem_read_unit: byte-addressed memory model drives db_in from ab,
// and each read is predicted from address rules, byte order and stall count.
module tb_mem_read_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wide;
    logic        zp_wrap;
    logic [15:0] addr_in;
    logic        rdy;
    logic [7:0]  db_in;
    logic [15:0] ab;
    logic        ab_valid;
    logic        busy;
    logic        done;
    logic [15:0] data_out;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_data;
    int          total;
    int          bad;

    mem_read_unit #(.ADDR_W(16), .RESET_AB(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wide     (wide),
        .zp_wrap  (zp_wrap),
        .addr_in  (addr_in),
        .rdy      (rdy),
        .db_in    (db_in),
        .ab       (ab),
        .ab_valid (ab_valid),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    assign db_in = mem[ab];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete read: rdy low for lo_st cycles on the lo byte and hi_st on the hi byte.
    task automatic do_read(input logic [15:0] a, input logic w, input logic z,
                           input int lo_st, input int hi_st);
        logic [15:0] a2;
        logic [15:0] expv;
        int          lat;
        int          got;
        if (z) a2 = (a & 16'hFF00) | ((a + 16'd1) & 16'h00FF);
        else   a2 = 16'((32'(a) + 1) % 65536);
        expv = w ? {mem[a2], mem[a]} : {8'h00, mem[a]};
        lat  = w ? (lo_st + hi_st + 2) : (lo_st + 1);
        addr_in = a; wide = w; zp_wrap = z; req = 1'b1; rdy = 1'b1;
        tick();
        req = 1'b0;
        addr_in = 16'($urandom); wide = 1'($urandom); zp_wrap = 1'($urandom);
        chk("busy_accept", {15'd0, busy}, 16'd1);
        chk("ab_valid_accept", {15'd0, ab_valid}, 16'd1);
        got = 0;
        for (int e = 1; e <= lat + 3 && got == 0; e++) begin
            if (e <= lat) begin
                chk("ab_seq", ab, (e <= lo_st + 1) ? a : a2);
                chk("done_early", {15'd0, done}, 16'd0);
                chk("data_hold", data_out, exp_data);
            end
            if (e <= lo_st || (w && e > lo_st + 1 && e <= lo_st + 1 + hi_st)) rdy = 1'b0;
            else rdy = 1'b1;
            tick();
            if (done) got = e;
        end
        rdy = 1'b1;
        chk("latency", 16'(got), 16'(lat));
        chk("data_out", data_out, expv);
        chk("busy_end", {15'd0, busy}, 16'd0);
        chk("ab_hold", ab, w ? a2 : a);
        exp_data = expv;
    endtask

    initial begin
        total = 0; bad = 0; exp_data = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b0; req = 1'b0; wide = 1'b0; zp_wrap = 1'b0; addr_in = 16'h0000; rdy = 1'b1;

        // reset held with the clock running
        repeat (3) tick();
        chk("rst_ab", ab, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ab_valid", {15'd0, ab_valid}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_data", data_out, 16'h0000);
        rst = 1'b1;
        addr_in = 16'h5555;
        repeat (3) tick();
        chk("idle_ab", ab, 16'h0000);
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_done", {15'd0, done}, 16'd0);
        chk("idle_data", data_out, 16'h0000);

        // directed reads
        mem[16'h0200] = 8'hA9;
        do_read(16'h0200, 1'b0, 1'b0, 0, 0);
        chk("byte_A9", data_out, 16'h00A9);
        mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        do_read(16'hFFFF, 1'b1, 1'b0, 0, 0);
        chk("word_FFFF", data_out, 16'h1234);
        mem[16'h00FF] = 8'hCD; mem[16'h0000] = 8'hAB; mem[16'h0100] = 8'hEE;
        do_read(16'h00FF, 1'b1, 1'b1, 0, 0);
        chk("zp_wrap", data_out, 16'hABCD);
        do_read(16'h3000, 1'b1, 1'b0, 3, 2);

        // back-to-back byte reads with req held high
        mem[16'h0400] = 8'h5A; mem[16'h0500] = 8'hC3;
        addr_in = 16'h0400; wide = 1'b0; zp_wrap = 1'b0; rdy = 1'b1; req = 1'b1;
        tick();
        chk("b2b_ab1", ab, 16'h0400);
        addr_in = 16'h0500;
        tick();
        chk("b2b_done1", {15'd0, done}, 16'd1);
        chk("b2b_data1", data_out, 16'h005A);
        tick();
        chk("b2b_gap_done", {15'd0, done}, 16'd0);
        chk("b2b_busy2", {15'd0, busy}, 16'd1);
        chk("b2b_ab2", ab, 16'h0500);
        chk("b2b_data_hold", data_out, 16'h005A);
        tick();
        req = 1'b0;
        chk("b2b_done2", {15'd0, done}, 16'd1);
        chk("b2b_data2", data_out, 16'h00C3);
        exp_data = 16'h00C3;
        tick();
        chk("b2b_done_clear", {15'd0, done}, 16'd0);

        // randomized reads, biased toward page and bus ends
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFF;
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            do_read(a, 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset while the hi byte is on the bus
        addr_in = 16'h1234; wide = 1'b1; zp_wrap = 1'b0; rdy = 1'b1; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        chk("abort_ab_hi", ab, 16'h1235);
        rst = 1'b0;
        #1;
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_data", data_out, 16'h0000);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_ab", ab, 16'h0000);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_abort_done", {15'd0, done}, 16'd0);
            chk("post_abort_data", data_out, 16'h0000);
        end
        exp_data = 16'h0000;
        do_read(16'h2000, 1'b1, 1'b0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
